// File: rtl/nibble_add_seq_if.sv
// Handshake/operand bundle for nibble_add_seq: the front end drives operands
// and start, the sequencer returns status and the committed result.
interface nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/nibble_add_seq.sv
// W-bit add/subtract built by time-sharing one 4-bit ripple adder, one nibble
// per clock, LSB first, with the carry held in a register between nibbles.
module ripple_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    nibble_add_seq_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IDX_W+1:0] bit_lo;
    logic [3:0]       nib_a, nib_b, add_sum;
    logic             add_cout;
    logic [W-1:0]     acc_new;

    // Current nibble is selected by shifting, so one adder serves every slice.
    assign bit_lo = {idx_q, 2'b00};
    assign nib_a  = 4'(a_q >> bit_lo);
    assign nib_b  = 4'(b_q >> bit_lo);

    ripple_add4 u_add (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q),
        .sum (add_sum),
        .cout(add_cout)
    );

    assign acc_new = (acc_q & ~(W'(4'hF) << bit_lo)) | (W'(add_sum) << bit_lo);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {W{bus.sub}};
                    carry_d = bus.cin ^ bus.sub;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_new;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Result becomes visible only here, on entry to DONE.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    sum_d   = acc_new;
                    cout_d  = add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (acc_new[W-1] != a_q[W-1]);
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
